// File: rtl/axilite_master_cmd_if.sv
// rtl/axilite_master_cmd_if.sv - AXI4-Lite bus bundle between the command initiator and a peripheral
interface axilite_master_cmd_if #(
    parameter int ADDR_W = 16
);
    // write address channel
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    // write data channel
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    // write response channel
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    // read address channel
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    // read data channel
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axilite_master_cmd.sv
// rtl/axilite_master_cmd.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp stream; optional watchdog under AXIL_MASTER_TIMEOUT_EN
module axilite_master_cmd #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_resp,

    output logic              timeout_err,

    axilite_master_cmd_if.master m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR_DATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } state_t;

    state_t state;

    // AW and W complete independently; each flag remembers an earlier handshake
    logic aw_done;
    logic w_done;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign accept = cmd_valid & cmd_ready;
    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_hs   = m_axi.wvalid  & m_axi.wready;
    assign b_hs   = m_axi.bvalid  & m_axi.bready;
    assign ar_hs  = m_axi.arvalid & m_axi.arready;
    assign r_hs   = m_axi.rvalid  & m_axi.rready;

    // Transaction sequencer: every output is a register updated here
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_data       <= '0;
            rsp_resp       <= '0;
            m_axi.awaddr   <= '0;
            m_axi.awvalid  <= 1'b0;
            m_axi.wdata    <= '0;
            m_axi.wstrb    <= '0;
            m_axi.wvalid   <= 1'b0;
            m_axi.bready   <= 1'b0;
            m_axi.araddr   <= '0;
            m_axi.arvalid  <= 1'b0;
            m_axi.rready   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi.awaddr  <= cmd_addr;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= S_WADDR_DATA;
                        end else begin
                            m_axi.araddr  <= cmd_addr;
                            m_axi.arvalid <= 1'b1;
                            state         <= S_RADDR;
                        end
                    end
                end

                S_WADDR_DATA: begin
                    if (aw_hs) begin
                        m_axi.awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi.wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // both channels finished, whether in this cycle or earlier
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        m_axi.bready <= 1'b1;
                        state        <= S_WRESP;
                    end
                end

                S_WRESP: begin
                    if (b_hs) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_data     <= '0;
                        rsp_write    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end

                S_RADDR: begin
                    if (ar_hs) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    if (r_hs) begin
                        m_axi.rready <= 1'b0;
                        rsp_data     <= m_axi.rdata;
                        rsp_resp     <= m_axi.rresp;
                        rsp_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_count;
    logic             wd_active;

    // the watchdog only runs while waiting on the slave
    assign wd_active = (state != S_IDLE) && (state != S_RSP);

    // Watchdog: flags a stalled slave but never interferes with the transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_count    <= '0;
            timeout_err <= 1'b0;
        end else if (accept) begin
            wd_count <= '0;
        end else if (wd_active) begin
            if (wd_count != CNT_W'(TIMEOUT_CYCLES)) begin
                wd_count <= wd_count + CNT_W'(1);
            end
            if (wd_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axilite_master_cmd.sv
// tb/tb_axilite_master_cmd.sv - directed bench with a protocol-level reference model for axilite_master_cmd
module tb_axilite_master_cmd;
    localparam int ADDR_W = 16;
    localparam int TO     = 16;

    logic              clock;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_resp;
    logic              timeout_err;

    axilite_master_cmd_if #(.ADDR_W(ADDR_W)) bus ();

    axilite_master_cmd #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m_axi       (bus.master)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // slave personality for the current test
    int          aw_delay  = 0;
    int          w_delay   = 0;
    int          ar_delay  = 0;
    int          b_delay   = 0;
    int          r_delay   = 0;
    int          rsp_delay = 0;
    logic        b_never   = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // per-transaction observations, in cycles relative to command accept
    int          acc_cyc        = 0;
    int          acc_gap        = 0;
    int          t_aw_first     = -1;
    int          t_aw_last      = -1;
    int          t_w_last       = -1;
    int          t_bready_first = -1;
    int          t_rready_first = -1;
    int          t_rsp_first    = -1;
    int          t_rsp_hs       = -1;
    int          rsp_count      = 0;
    logic        cap_write      = 1'b0;
    logic [31:0] cap_data       = 32'h0;
    logic [1:0]  cap_resp       = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    // Behavioural AXI-Lite peripheral and response consumer, driven on falling edges
    initial begin
        int   aw_wait, w_wait, ar_wait, b_wait, r_wait, rs_wait;
        logic aw_got, w_got, ar_got;
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs, rs_hs;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; rs_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rs_hs = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        rsp_ready = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; rs_wait = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rs_hs = 0;
                bus.awready = 0; bus.wready = 0; bus.arready = 0;
                bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
                rsp_ready = 0;
            end else begin
                if (aw_hs) begin bus.awready = 0; aw_got = 1; aw_wait = 0; aw_hs = 0; end
                if (w_hs)  begin bus.wready  = 0; w_got  = 1; w_wait  = 0; w_hs  = 0; end
                if (ar_hs) begin bus.arready = 0; ar_got = 1; ar_wait = 0; ar_hs = 0; end
                if (b_hs)  begin bus.bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; b_hs = 0; end
                if (r_hs)  begin bus.rvalid = 0; ar_got = 0; r_wait = 0; r_hs = 0; end
                if (rs_hs) begin rsp_ready = 0; rs_wait = 0; rs_hs = 0; end

                if (bus.awvalid && !aw_got) begin
                    if (aw_wait >= aw_delay) bus.awready = 1; else aw_wait++;
                end
                if (bus.wvalid && !w_got) begin
                    if (w_wait >= w_delay) bus.wready = 1; else w_wait++;
                end
                if (bus.arvalid && !ar_got) begin
                    if (ar_wait >= ar_delay) bus.arready = 1; else ar_wait++;
                end
                if (aw_got && w_got && !b_never && !bus.bvalid) begin
                    if (b_wait >= b_delay) begin bus.bvalid = 1; bus.bresp = cfg_bresp; end
                    else b_wait++;
                end
                if (ar_got && !bus.rvalid) begin
                    if (r_wait >= r_delay) begin
                        bus.rvalid = 1; bus.rdata = cfg_rdata; bus.rresp = cfg_rresp;
                    end else r_wait++;
                end
                if (rsp_valid && !rsp_ready) begin
                    if (rs_wait >= rsp_delay) rsp_ready = 1; else rs_wait++;
                end

                aw_hs = bus.awvalid && bus.awready;
                w_hs  = bus.wvalid  && bus.wready;
                ar_hs = bus.arvalid && bus.arready;
                b_hs  = bus.bvalid  && bus.bready;
                r_hs  = bus.rvalid  && bus.rready;
                rs_hs = rsp_valid   && rsp_ready;
            end
        end
    end

    // Reference model: which phase of the single outstanding transaction we are in, checked every cycle
    initial begin
        logic        busy, ew, aws, ws, bs, ars, rs, erw;
        logic [15:0] ea;
        logic [31:0] ed, erd;
        logic [3:0]  es;
        logic [1:0]  er;
        int          rel;
        busy = 0; ew = 0; aws = 0; ws = 0; bs = 0; ars = 0; rs = 0; erw = 0;
        ea = 0; ed = 0; erd = 0; es = 0; er = 0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                busy = 0; aws = 0; ws = 0; bs = 0; ars = 0; rs = 0;
            end else begin
                rel = cyc - acc_cyc;
                chk("cmd_ready", cmd_ready, !busy);
                chk("awvalid", bus.awvalid, busy && ew && !aws);
                chk("wvalid", bus.wvalid, busy && ew && !ws);
                chk("arvalid", bus.arvalid, busy && !ew && !ars);
                chk("bready", bus.bready, busy && ew && aws && ws && !bs);
                chk("rready", bus.rready, busy && !ew && ars && !rs);
                chk("rsp_valid", rsp_valid, busy && (bs || rs));
`ifndef AXIL_MASTER_TIMEOUT_EN
                chk("timeout_err_off", timeout_err, 0);
`endif
                if (bus.awvalid) begin
                    chk("awaddr", bus.awaddr, ea);
                    if (t_aw_first < 0) t_aw_first = rel;
                    t_aw_last = rel;
                end
                if (bus.wvalid) begin
                    chk("wdata", bus.wdata, ed);
                    chk("wstrb", bus.wstrb, es);
                    t_w_last = rel;
                end
                if (bus.arvalid) chk("araddr", bus.araddr, ea);
                if (bus.bready && t_bready_first < 0) t_bready_first = rel;
                if (bus.rready && t_rready_first < 0) t_rready_first = rel;
                if (rsp_valid) begin
                    chk("rsp_write", rsp_write, erw);
                    chk("rsp_data", rsp_data, erd);
                    chk("rsp_resp", rsp_resp, er);
                    if (t_rsp_first < 0) t_rsp_first = rel;
                end

                if (bus.awvalid && bus.awready) aws = 1;
                if (bus.wvalid && bus.wready) ws = 1;
                if (bus.arvalid && bus.arready) ars = 1;
                if (bus.bvalid && bus.bready) begin bs = 1; erw = 1; erd = 0; er = bus.bresp; end
                if (bus.rvalid && bus.rready) begin rs = 1; erw = 0; erd = bus.rdata; er = bus.rresp; end
                if (rsp_valid && rsp_ready) begin
                    busy = 0;
                    cap_write = rsp_write; cap_data = rsp_data; cap_resp = rsp_resp;
                    t_rsp_hs = rel;
                    rsp_count++;
                end
                if (cmd_valid && cmd_ready) begin
                    busy = 1; ew = cmd_write; ea = cmd_addr; ed = cmd_wdata; es = cmd_wstrb;
                    aws = 0; ws = 0; bs = 0; ars = 0; rs = 0;
                    acc_gap = cyc - acc_cyc;
                    acc_cyc = cyc;
                    t_aw_first = -1; t_aw_last = -1; t_w_last = -1;
                    t_bready_first = -1; t_rready_first = -1; t_rsp_first = -1;
                end
            end
        end
    end

    // caller sits at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) chk("cmd_accept_bound", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (rsp_count < target) chk("rsp_bound", rsp_count, target);
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        reset = 1;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 0;
        @(negedge clock);

        // zero-wait write
        issue(1, 16'h0004, 32'h0000_000C, 4'hF);
        wait_rsp(1);
        chk("t1_aw_first", t_aw_first, 1);
        chk("t1_rsp_first", t_rsp_first, 3);
        chk("t1_rsp_write", cap_write, 1);
        chk("t1_rsp_resp", cap_resp, 2'b00);
        chk("t1_rsp_data", cap_data, 0);

        // AW delayed three cycles, W immediate
        aw_delay = 3;
        issue(1, 16'h0004, 32'h0000_00C3, 4'h5);
        wait_rsp(2);
        chk("t2_w_last", t_w_last, 1);
        chk("t2_aw_last", t_aw_last, 4);
        chk("t2_bready_first", t_bready_first, 5);
        chk("t2_rsp_first", t_rsp_first, 6);
        aw_delay = 0;

        // read with two wait cycles on R
        r_delay = 2; cfg_rdata = 32'h0000_005A; cfg_rresp = 2'b00;
        issue(0, 16'h0000, 32'h0, 4'h0);
        wait_rsp(3);
        chk("t3_rready_first", t_rready_first, 2);
        chk("t3_rsp_first", t_rsp_first, 5);
        chk("t3_rsp_data", cap_data, 32'h0000_005A);
        chk("t3_rsp_write", cap_write, 0);
        chk("t3_rsp_resp", cap_resp, 2'b00);
        r_delay = 0;

        // SLVERR write then DECERR read pass straight through
        cfg_bresp = 2'b10;
        issue(1, 16'h0008, 32'hA5A5_0001, 4'h3);
        wait_rsp(4);
        chk("t4_bresp", cap_resp, 2'b10);
        cfg_bresp = 2'b00;
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b11;
        issue(0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(5);
        chk("t4_rresp", cap_resp, 2'b11);
        chk("t4_rdata", cap_data, 32'hDEAD_BEEF);
        chk("t4_rsp_first", t_rsp_first, 3);
        cfg_rresp = 2'b00;

        // response back-pressure for five cycles, next command waiting behind it
        rsp_delay = 5; cfg_rdata = 32'h1234_5678;
        issue(0, 16'h0020, 32'h0, 4'h0);
        issue(1, 16'h0024, 32'h0BAD_F00D, 4'hC);
        chk("t5_rsp_hs", t_rsp_hs, 8);
        chk("t5_rsp_data", cap_data, 32'h1234_5678);
        chk("t5_accept_gap", acc_gap, 9);
        wait_rsp(7);
        chk("t5_w_rsp_write", cap_write, 1);
        rsp_delay = 0;

        // slave never answers the write
        b_never = 1;
        issue(1, 16'h0030, 32'h5555_AAAA, 4'hF);
        repeat (12) @(negedge clock);
`ifdef AXIL_MASTER_TIMEOUT_EN
        chk("t6_timeout_early", timeout_err, 0);
`endif
        repeat (8) @(negedge clock);
`ifdef AXIL_MASTER_TIMEOUT_EN
        chk("t6_timeout_set", timeout_err, 1);
`else
        chk("t6_timeout_off", timeout_err, 0);
`endif
        chk("t6_bready_held", bus.bready, 1);
        chk("t6_no_rsp", rsp_valid, 0);
        reset = 1;
        @(negedge clock);
        chk("t6_rst_cmd_ready", cmd_ready, 1);
        chk("t6_rst_bready", bus.bready, 0);
        chk("t6_rst_awaddr", bus.awaddr, 0);
        chk("t6_rst_wdata", bus.wdata, 0);
        chk("t6_rst_timeout", timeout_err, 0);
        @(negedge clock);
        reset = 0;
        b_never = 0;
        @(negedge clock);

        // recovery after reset
        cfg_rdata = 32'h0000_0077;
        issue(0, 16'h0040, 32'h0, 4'h0);
        wait_rsp(8);
        chk("t7_rsp_first", t_rsp_first, 3);
        chk("t7_rsp_data", cap_data, 32'h0000_0077);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
